// File: rtl/data_mem_responder_pkg.sv
// Shared address map, region/state types and the address decoder for the
// CPU data-memory responder.
package cpu_mem_pkg;

  localparam logic [14:0] RAM_BASE = 15'h0000;
  localparam logic [14:0] SCR_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {REG_RAM, REG_SCR, REG_KBD, REG_NONE} region_t;

  typedef enum logic [2:0] {IDLE, RAM_DATA, DRAIN, EXT_RD, EXT_DATA} resp_state_t;

  function automatic region_t decode_region(input logic [14:0] addr);
    if (addr < SCR_BASE) return REG_RAM;
    if (addr < KBD_ADDR) return REG_SCR;
    if (addr == KBD_ADDR) return REG_KBD;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/data_mem_responder_wbuf_fifo.sv
// Posted-write buffer for the screen port: small circular FIFO of {addr,data}.
// Push while full is accepted only when a pop happens in the same cycle.
module wbuf_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 29,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: decodes RAM / screen / keyboard, returns in_m,
// stalls the CPU on slow reads and posts screen writes through wbuf_fifo.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int RAM_AW     = 14,
  parameter int WBUF_DEPTH = 2,
  parameter int SW_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [14:0]         data_addr,
  input  logic [15:0]         out_m,
  input  logic                write_m,
  input  logic                read_m,
  output logic [15:0]         in_m,
  output logic                stall,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                ext_req,
  output logic                ext_we,
  output logic [12:0]         ext_addr,
  output logic [15:0]         ext_wdata,
  input  logic [15:0]         ext_rdata,
  input  logic                ext_ack
);

  localparam int WB_W  = 29;
  localparam int WB_CW = $clog2(WBUF_DEPTH + 1);

  resp_state_t         state;
  region_t             region;
  logic [15:0]         mem [2**RAM_AW];
  logic [15:0]         ram_q;
  logic [15:0]         rd_hold;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;

  logic             wb_push, wb_pop, wb_full, wb_empty;
  logic [WB_W-1:0]  wb_dout;
  logic [WB_CW-1:0] wb_count;

  logic wr_ok, ram_we, ram_re, ext_done, drain_go, rd_go;

  assign region = decode_region(data_addr);

  // stall never depends on write_m, so gating writes with it creates no loop
  assign stall = wb_full
               | ((state == IDLE) & read_m & ((region == REG_RAM) | (region == REG_SCR)))
               | (state == DRAIN) | (state == EXT_RD);

  assign wr_ok    = write_m & ~stall;
  assign ram_we   = wr_ok & (region == REG_RAM);
  assign wb_push  = wr_ok & (region == REG_SCR);
  assign ram_re   = (state == IDLE) & read_m & (region == REG_RAM) & ~wb_full;

  // a buffered write leaves the FIFO only once the screen acknowledges it,
  // so "wbuf empty" also means no screen write is in flight
  assign ext_done = ext_req & ext_ack;
  assign wb_pop   = ext_done & ext_we;
  assign drain_go = ~ext_req & ~wb_empty & (state != EXT_RD);
  assign rd_go    = ~ext_req &
                    (((state == IDLE) & read_m & (region == REG_SCR) & ~wb_full & (wb_count == '0))
                     | ((state == DRAIN) & wb_empty));

  wbuf_fifo #(.DEPTH(WBUF_DEPTH), .W(WB_W)) u_wbuf (
    .clk    (clk),
    .resetN (resetN),
    .push   (wb_push),
    .pop    (wb_pop),
    .din    ({data_addr[12:0], out_m}),
    .dout   (wb_dout),
    .empty  (wb_empty),
    .full   (wb_full),
    .count  (wb_count)
  );

  always_ff @(posedge clk) begin
    if (ram_we) mem[data_addr[RAM_AW-1:0]] <= out_m;
    if (ram_re) ram_q <= mem[data_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      rd_hold   <= '0;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_re) state <= RAM_DATA;
          else if (rd_go) state <= EXT_RD;
          else if (read_m && !wb_full && region == REG_SCR) state <= DRAIN;
        end
        DRAIN:    if (rd_go) state <= EXT_RD;
        EXT_RD: begin
          if (ext_done) begin
            rd_hold <= ext_rdata;
            state   <= EXT_DATA;
          end
        end
        RAM_DATA: state <= IDLE;
        EXT_DATA: state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (ext_done) begin
        ext_req <= 1'b0;
      end else if (drain_go) begin
        ext_req   <= 1'b1;
        ext_we    <= 1'b1;
        ext_addr  <= wb_dout[28:16];
        ext_wdata <= wb_dout[15:0];
      end else if (rd_go) begin
        ext_req  <= 1'b1;
        ext_we   <= 1'b0;
        ext_addr <= data_addr[12:0];
      end
    end
  end

  always_comb begin
    in_m = '0;
    case (state)
      RAM_DATA: in_m = ram_q;
      EXT_DATA: in_m = rd_hold;
      IDLE:     if (read_m && region == REG_KBD) in_m = 16'(sw_sync);
      default:  in_m = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a behavioural screen responder
// that acks three cycles after each request and logs {we, addr}.
module tb_data_mem_responder;

  logic        clk;
  logic        resetN;
  logic [14:0] data_addr;
  logic [15:0] out_m;
  logic        write_m;
  logic        read_m;
  logic [15:0] in_m;
  logic        stall;
  logic [3:0]  SW;
  logic        ext_req;
  logic        ext_we;
  logic [12:0] ext_addr;
  logic [15:0] ext_wdata;
  logic [15:0] ext_rdata;
  logic        ext_ack;

  logic        resp_ack;
  logic        man_ack;
  logic        ack_en;
  logic [15:0] scr [8192];
  logic [13:0] ext_log [$];

  int n_chk;
  int n_pass;

  assign ext_ack = resp_ack | man_ack;

  data_mem_responder #(.RAM_AW(14), .WBUF_DEPTH(2), .SW_WIDTH(4)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .data_addr (data_addr),
    .out_m     (out_m),
    .write_m   (write_m),
    .read_m    (read_m),
    .in_m      (in_m),
    .stall     (stall),
    .SW        (SW),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // screen model: ack sampled on the third rising edge after req is seen
  initial begin
    resp_ack  = 1'b0;
    ext_rdata = '0;
    for (int i = 0; i < 8192; i++) scr[i] = 16'h5000 + 16'(i);
    forever begin
      @(negedge clk);
      if (ext_req && ack_en) begin
        repeat (2) @(negedge clk);
        resp_ack  = 1'b1;
        ext_rdata = ext_we ? 16'h0000 : scr[ext_addr];
        if (ext_we) scr[ext_addr] = ext_wdata;
        ext_log.push_back({ext_we, ext_addr});
        @(negedge clk);
        resp_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      read_m  = 1'b0;
      write_m = 1'b0;
    end
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d, output int stalls);
    stalls = 99;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      data_addr = a;
      out_m     = d;
      read_m    = 1'b0;
      write_m   = 1'b0;
      #1;
      if (!stall) begin
        write_m = 1'b1;
        stalls  = i;
        break;
      end
    end
  endtask

  task automatic cpu_read(input logic [14:0] a, input logic do_wr, input logic [15:0] wd,
                          output logic [15:0] d, output int stalls);
    stalls = 99;
    d      = 16'hxxxx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      data_addr = a;
      read_m    = 1'b1;
      write_m   = 1'b0;
      #1;
      if (!stall) begin
        d       = in_m;
        stalls  = i;
        write_m = do_wr;
        out_m   = wd;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] rd;
    int st;

    n_chk = 0;
    n_pass = 0;
    resetN = 1'b0;
    data_addr = '0;
    out_m = '0;
    write_m = 1'b0;
    read_m = 1'b0;
    SW = 4'b0000;
    man_ack = 1'b0;
    ack_en = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_m", in_m, 16'h0000);
    chk("rst_stall", 16'(stall), 16'h0000);
    chk("rst_ext_req", 16'(ext_req), 16'h0000);
    chk("rst_ext_we", 16'(ext_we), 16'h0000);
    chk("rst_ext_addr", 16'(ext_addr), 16'h0000);
    chk("rst_ext_wdata", ext_wdata, 16'h0000);
    @(negedge clk);
    resetN = 1'b1;
    idle(2);

    // RAM write then read: one stall cycle
    cpu_write(15'h0100, 16'h1234, st);
    cpu_read(15'h0100, 1'b0, 16'h0, rd, st);
    chk("ram_rd_stalls", 16'(st), 16'd1);
    chk("ram_rd_data", rd, 16'h1234);
    cpu_write(15'h3FFF, 16'h0F0F, st);
    cpu_read(15'h3FFF, 1'b0, 16'h0, rd, st);
    chk("ram_top_stalls", 16'(st), 16'd1);
    chk("ram_top_data", rd, 16'h0F0F);

    // keyboard and unmapped reads
    SW = 4'b1010;
    idle(3);
    cpu_read(15'h6000, 1'b0, 16'h0, rd, st);
    chk("kbd_stalls", 16'(st), 16'd0);
    chk("kbd_data", rd, 16'h000A);
    cpu_read(15'h7000, 1'b0, 16'h0, rd, st);
    chk("unmap_stalls", 16'(st), 16'd0);
    chk("unmap_data", rd, 16'h0000);
    idle(2);

    // three posted screen writes into a 2-deep buffer
    ext_log.delete();
    cpu_write(15'h4000, 16'hA000, st);
    chk("scr_w0_stalls", 16'(st), 16'd0);
    cpu_write(15'h4001, 16'hA001, st);
    chk("scr_w1_stalls", 16'(st), 16'd0);
    cpu_write(15'h4002, 16'hA002, st);
    chk("scr_w2_stalls", 16'(st), 16'd3);
    for (int i = 0; i < 60 && ext_log.size() < 3; i++) idle(1);
    idle(3);
    chk("scr_w_count", 16'(ext_log.size()), 16'd3);
    if (ext_log.size() == 3) begin
      chk("scr_w_order0", 16'(ext_log[0]), 16'h2000);
      chk("scr_w_order1", 16'(ext_log[1]), 16'h2001);
      chk("scr_w_order2", 16'(ext_log[2]), 16'h2002);
    end
    chk("scr_data0", scr[0], 16'hA000);
    chk("scr_data1", scr[1], 16'hA001);
    chk("scr_data2", scr[2], 16'hA002);

    // write then immediate read of same screen word: drain before read
    ext_log.delete();
    cpu_write(15'h4005, 16'hBEEF, st);
    cpu_read(15'h4005, 1'b0, 16'h0, rd, st);
    chk("scr_rd_stalls", 16'(st), 16'd8);
    chk("scr_rd_data", rd, 16'hBEEF);
    chk("scr_rd_count", 16'(ext_log.size()), 16'd2);
    if (ext_log.size() == 2) begin
      chk("scr_rd_first", 16'(ext_log[0]), 16'h2005);
      chk("scr_rd_second", 16'(ext_log[1]), 16'h0005);
    end
    idle(3);

    // read-modify-write at RAM 0x0010
    cpu_write(15'h0010, 16'h0007, st);
    cpu_read(15'h0010, 1'b1, 16'h0008, rd, st);
    chk("rmw_stalls", 16'(st), 16'd1);
    chk("rmw_old", rd, 16'h0007);
    cpu_read(15'h0010, 1'b0, 16'h0, rd, st);
    chk("rmw_new", rd, 16'h0008);
    idle(3);

    // reset while a screen write is in flight and a read waits in DRAIN
    ack_en = 1'b0;
    ext_log.delete();
    cpu_write(15'h4010, 16'hC010, st);
    @(negedge clk);
    data_addr = 15'h4012;
    write_m = 1'b0;
    read_m = 1'b1;
    #1;
    chk("rst_seq_stall", 16'(stall), 16'h0001);
    @(negedge clk);
    #1;
    chk("rst_seq_req", 16'({ext_req, ext_we, ext_addr}), 16'h6010);
    @(negedge clk);
    resetN = 1'b0;
    read_m = 1'b0;
    #1;
    chk("rst_mid_req", 16'(ext_req), 16'h0000);
    chk("rst_mid_stall", 16'(stall), 16'h0000);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    #1;
    chk("late_ack_req", 16'(ext_req), 16'h0000);
    chk("late_ack_stall", 16'(stall), 16'h0000);
    chk("late_ack_in_m", in_m, 16'h0000);
    ack_en = 1'b1;
    cpu_read(15'h4012, 1'b0, 16'h0, rd, st);
    chk("post_rst_stalls", 16'(st), 16'd4);
    chk("post_rst_data", rd, 16'h5012);
    chk("post_rst_log", 16'(ext_log.size()), 16'd1);
    if (ext_log.size() == 1) chk("post_rst_rd", 16'(ext_log[0]), 16'h0012);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
